adc_pipe_align_encoder: RTL
===========================

# adc_pipe_align_encoder

Parametrised successor of the 3-stage pipelined ADC encoder. It accepts NUM_STAGES one-hot stage decisions (1.5-bit stages plus a final 1-bit stage) and time-aligns them, since stage k reports one cycle after stage k-1. It then applies digital error correction by overlapping addition, flags malformed one-hot words, and keeps a saturating error count. It sits between the analog stage comparators and the digital back-end. Unlike its predecessor, it has a valid strobe, per-sample error flagging and a configurable stage count.

## Interface
Parameters:
- NUM_STAGES, default 3: total stages, ≥2; output width equals NUM_STAGES.
- ONEHOT_WIDTH, default 3: one-hot width per stage; fixed at 3 for 1.5-bit stages.
- CNT_WIDTH, default 8: error counter width.

Ports (reset is synchronous, active-high, on clock_i):
- clock_i  in  1  single clock; all state updates on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- valid_i  in  1  asserted with the stage-1 word of a new sample.
- d_stage_i  in  NUM_STAGES*3  one-hot words; stage 1 at MSBs, stage NUM_STAGES at LSBs.
- err_clr_i  in  1  clears err_cnt_o.
- d_o  out  NUM_STAGES  corrected output code.
- valid_o  out  1  d_o and code_err_o are valid.
- code_err_o  out  1  at least one stage word of this sample was not one-hot.
- err_cnt_o  out  CNT_WIDTH  saturating count of errored output samples.

## Operation
- Per-stage decode:
  - 001 → code 0; 010 → code 1; 100 → code 2.
  - Any other pattern (000, multiple bits set) → code 1 (mid-scale, minimum-error substitute) and a per-stage error bit.
- Stage code c_i, for i = 1..NUM_STAGES-1, has weight 2^(NUM_STAGES-1-i).
- The last stage contributes b = (code == 2) at weight 2^0.
- Correction: d = Σ c_i·2^(NUM_STAGES-1-i) + b.
  - The maximum is 2·(2^(NUM_STAGES-1)-1)+1 = 2^NUM_STAGES-1, so the result always fits NUM_STAGES bits.
  - No saturation is needed. Compute the sum in NUM_STAGES+1 bits and take the low NUM_STAGES bits.
- Alignment: the decoded code and error bit of stage i pass through NUM_STAGES-i register stages. The last stage is not delayed before summation.
- valid_i passes through a NUM_STAGES-1 deep shift register matching stage 1.
- Output register: d_o, valid_o and code_err_o load every cycle from the aligned sum, the aligned valid, and the OR of the aligned error bits.
  - Samples with valid low still propagate. Consumers must qualify with valid_o.
- Error counter:
  - Increments when valid_o && code_err_o, evaluated on the registered outputs, so the count updates one cycle after the flagged sample appears.
  - Saturates at 2^CNT_WIDTH-1.
  - err_clr_i wins over a simultaneous increment: the counter goes to 0.
- The pipeline is free-running with no back-pressure.

## Timing
- Sample stage 1 arrives at cycle t (with valid_i). Stage k of the same sample arrives at t+k-1.
- d_o, valid_o and code_err_o appear at t+NUM_STAGES. Latency is NUM_STAGES cycles, throughput is one sample per cycle.
- err_cnt_o reflects that sample at t+NUM_STAGES+1.
- Reset values: d_o=0, valid_o=0, code_err_o=0, err_cnt_o=0. All alignment registers are cleared to code 0 with no error, and the valid pipe is cleared to 0.
- Reset mid-operation: all in-flight samples are discarded. valid_o stays 0 until NUM_STAGES cycles after the first valid_i following reset deassertion.
- Back-to-back valid_i: every sample emerges in order with no gaps or duplication.

## Structure
- Shared package adc_pipe_pkg holds:
  - ONEHOT_WIDTH=3 and CODE_WIDTH=2;
  - code constants CODE_LO=0, CODE_MID=1, CODE_HI=2;
  - the invalid-substitute code (CODE_MID).
- One sub-module: adc_onehot_dec, a combinational 3-bit one-hot to 2-bit code converter with an err output. It is instantiated NUM_STAGES times in a generate loop.
- Alignment delays use a generate loop per stage. The counter is an inline always block.

## Test plan
- NUM_STAGES=3, single valid sample with stage words 100/010/100 at t, t+1, t+2 → d_o=6, valid_o=1, code_err_o=0 at t+3.
- NUM_STAGES=3, extremes: all stages 001 → d_o=0; all stages 100 → d_o=7. Run both back-to-back and check no inter-sample mixing.
- NUM_STAGES=3, stage 2 word 011 → code treated as 1, code_err_o=1 with the sample; err_cnt_o increments by 1 one cycle later.
- Counter: force errors for 260 samples with CNT_WIDTH=8 → err_cnt_o holds 255. Assert err_clr_i in the same cycle as an errored sample → err_cnt_o=0.
- NUM_STAGES=4, stages 100/001/010/100 → d_o=10 at latency 4. Assert reset_i at t+2 → no valid_o for that sample.
- Random one-hot streams with random valid_i, checked against a reference model of d = Σ c_i·2^(N-1-i)+b at latency N, for N=2,3,6.

Source files
------------

// File: rtl/adc_pipe_pkg.sv
// Shared types and constants for the pipelined ADC alignment encoder.
// Stage words are 3-bit one-hot; decoded codes are 2-bit.
package adc_pipe_pkg;

    localparam int ONEHOT_WIDTH = 3;
    localparam int CODE_WIDTH   = 2;

    typedef logic [CODE_WIDTH-1:0] code_t;

    localparam code_t CODE_LO  = 2'd0;
    localparam code_t CODE_MID = 2'd1;
    localparam code_t CODE_HI  = 2'd2;

    // Mid-scale is the minimum-error guess when a stage word is malformed.
    localparam code_t CODE_INVALID = CODE_MID;

endpackage

// File: rtl/adc_onehot_dec.sv
// Combinational one-hot stage word to 2-bit code converter.
// Any pattern that is not exactly one-hot yields the substitute code and err=1.
module adc_onehot_dec
    import adc_pipe_pkg::*;
(
    input  logic [ONEHOT_WIDTH-1:0] onehot,
    output code_t                   code,
    output logic                    err
);

    always_comb begin
        code = CODE_INVALID;
        err  = 1'b1;
        case (onehot)
            3'b001: begin
                code = CODE_LO;
                err  = 1'b0;
            end
            3'b010: begin
                code = CODE_MID;
                err  = 1'b0;
            end
            3'b100: begin
                code = CODE_HI;
                err  = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/adc_pipe_align_encoder.sv
// Time-aligns staggered pipelined-ADC stage decisions, applies overlap-add
// digital error correction, flags malformed words and counts errored samples.
module adc_pipe_align_encoder
    import adc_pipe_pkg::*;
#(
    parameter int NUM_STAGES   = 3,
    parameter int ONEHOT_WIDTH = 3,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               valid_i,
    input  logic [NUM_STAGES*ONEHOT_WIDTH-1:0] d_stage_i,
    input  logic                               err_clr_i,
    output logic [NUM_STAGES-1:0]              d_o,
    output logic                               valid_o,
    output logic                               code_err_o,
    output logic [CNT_WIDTH-1:0]               err_cnt_o
);

    // valid_i marks the cycle carrying stage 1 of a sample; valid_o marks the
    // cycle d_o/code_err_o belong to that sample. No back-pressure exists, so
    // every cycle produces an output and consumers must qualify with valid_o.

    localparam int SUM_W = NUM_STAGES + 1;

    code_t                   dec_code [NUM_STAGES];
    logic                    dec_err  [NUM_STAGES];
    code_t                   aln_code [NUM_STAGES];
    logic                    aln_err  [NUM_STAGES];
    logic [NUM_STAGES-2:0]   valid_pipe;
    logic [SUM_W-1:0]        sum;
    logic                    err_any;
    logic [NUM_STAGES-1:0]   d_next;

    // Stage s (0 = stage 1) arrives NUM_STAGES-1-s cycles before the last
    // stage, so it is held that many cycles to line up with it.
    generate
        for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
            localparam int DEPTH = NUM_STAGES - 1 - s;

            adc_onehot_dec u_dec (
                .onehot (d_stage_i[(NUM_STAGES-1-s)*ONEHOT_WIDTH +: ONEHOT_WIDTH]),
                .code   (dec_code[s]),
                .err    (dec_err[s])
            );

            if (DEPTH > 0) begin : g_delay
                code_t            dly_code [DEPTH];
                logic [DEPTH-1:0] dly_err;

                always_ff @(posedge clock_i) begin
                    if (reset_i) begin
                        for (int j = 0; j < DEPTH; j++) begin
                            dly_code[j] <= CODE_LO;
                        end
                        dly_err <= '0;
                    end else begin
                        dly_code[0] <= dec_code[s];
                        dly_err[0]  <= dec_err[s];
                        for (int j = 1; j < DEPTH; j++) begin
                            dly_code[j] <= dly_code[j-1];
                            dly_err[j]  <= dly_err[j-1];
                        end
                    end
                end

                assign aln_code[s] = dly_code[DEPTH-1];
                assign aln_err[s]  = dly_err[DEPTH-1];
            end else begin : g_direct
                assign aln_code[s] = dec_code[s];
                assign aln_err[s]  = dec_err[s];
            end
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe[0] <= valid_i;
            for (int j = 1; j < NUM_STAGES - 1; j++) begin
                valid_pipe[j] <= valid_pipe[j-1];
            end
        end
    end

    // Overlap-add: each 1.5-bit stage carries weight 2^(N-1-i); the final
    // 1-bit stage only contributes its top decision. The sum never overflows.
    always_comb begin
        sum     = '0;
        err_any = 1'b0;
        for (int s = 0; s < NUM_STAGES - 1; s++) begin
            sum = sum + (SUM_W'(aln_code[s]) << (NUM_STAGES - 2 - s));
        end
        sum = sum + SUM_W'(aln_code[NUM_STAGES-1] == CODE_HI);
        for (int s = 0; s < NUM_STAGES; s++) begin
            err_any = err_any | aln_err[s];
        end
    end

    assign d_next = NUM_STAGES'(sum);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            d_o        <= '0;
            valid_o    <= 1'b0;
            code_err_o <= 1'b0;
        end else begin
            d_o        <= d_next;
            valid_o    <= valid_pipe[NUM_STAGES-2];
            code_err_o <= err_any;
        end
    end

    // Counts from the registered outputs; a clear beats a coincident increment.
    always_ff @(posedge clock_i) begin
        if (reset_i || err_clr_i) begin
            err_cnt_o <= '0;
        end else if (valid_o && code_err_o && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + 1'b1;
        end
    end

endmodule
